// File: rtl/mem_stream_pkg.sv
// Shared types and sizing helpers for the memory stream reader.
// Purely declarative: no logic, no timing of its own.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Enough slots for every read in flight plus one word stalled at the output
    // and one being refilled, so a ready consumer sees one word per clock.
    function automatic int buf_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_stream_buf_m.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// Pushed word is visible on the next cycle; producer must respect count_o (no full flag).
module mem_stream_buf_m
    import mem_stream_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 3,
    parameter int CNT_W = ptr_width(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             pop_vld_o,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = ptr_width(DEPTH);

    logic [AW-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;

    assign do_pop    = pop_i && (cnt_q != '0);
    assign pop_vld_o = (cnt_q != '0);
    assign count_o   = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    // Pointers wrap at the power-of-two RAM depth; occupancy never exceeds DEPTH.
    sdp_distributed_ram_m #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (WIDTH),
        .OUT_REGISTERED ("NO")
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push_i && !clr_i),
        .waddr_i (wr_q),
        .wdata_i (push_dat_i),
        .raddr_i (rd_q),
        .rdata_o (pop_dat_o)
    );

endmodule

// File: rtl/sdp_distributed_ram_m.sv
// Simple-dual-port distributed RAM: one synchronous write port, one read port.
// Read latency 0 (OUT_REGISTERED="NO") or 1 ("YES"); no flow control.
module sdp_distributed_ram_m #(
    parameter int    ADDR_WIDTH     = 2,
    parameter int    DATA_WIDTH     = 17,
    parameter string OUT_REGISTERED = "NO"
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (OUT_REGISTERED == "YES") begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk_i) begin
                rdata_q <= mem_q[raddr_i];
            end
            assign rdata_o = rdata_q;
        end else begin : g_comb
            assign rdata_o = mem_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/mem_stream_reader_m.sv
// Walks a RAM address range and streams the words out; first word READ_LATENCY+2 cycles after start.
// Credit-limited issue, full m_ready backpressure; MEM_STREAM_READER_ABORT_EN adds an abort input.
module mem_stream_reader_m
    import mem_stream_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int WORD_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic                  m_valid,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
`ifdef MEM_STREAM_READER_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    localparam int BUF_DEPTH = buf_depth(READ_LATENCY);
    localparam int CNT_W     = ptr_width(BUF_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(BUF_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic                  done_q, done_d;
    logic                  issue, issue_last, flush;
    logic                  cap_vld, cap_last;
    logic [CNT_W-1:0]      inflight, buf_cnt;
    logic [CNT_W:0]        occ;
    logic                  buf_vld, pop;
    logic [WORD_WIDTH:0]   buf_dat;

    assign occ = {1'b0, buf_cnt} + {1'b0, inflight};
    assign pop = buf_vld && m_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d  = ISSUE;
                        addr_d   = base_addr;
                        remain_d = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (occ < DEPTH_L) begin
                    issue      = 1'b1;
                    issue_last = (remain_q == (ADDR_WIDTH+1)'(1));
                    remain_d   = remain_q - (ADDR_WIDTH+1)'(1);
                    // raddr parks on the final address rather than running one past it.
                    if (issue_last) state_d = DRAIN;
                    else            addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (pop && buf_dat[WORD_WIDTH]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_STREAM_READER_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            addr_d     = addr_q;
            remain_d   = '0;
            issue      = 1'b0;
            issue_last = 1'b0;
            flush      = 1'b1;
            done_d     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    // Issue-flag delay line matching the RAM read latency; its output marks rdata as valid.
    generate
        if (READ_LATENCY == 0) begin : g_comb
            assign cap_vld  = issue;
            assign cap_last = issue_last;
            assign inflight = '0;
        end else begin : g_pipe
            logic [READ_LATENCY-1:0] vld_q, last_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= '0;
                    last_q <= '0;
                end else if (flush) begin
                    vld_q  <= '0;
                    last_q <= '0;
                end else begin
                    vld_q  <= (vld_q << 1)  | READ_LATENCY'(issue);
                    last_q <= (last_q << 1) | READ_LATENCY'(issue_last);
                end
            end
            always_comb begin
                inflight = '0;
                for (int i = 0; i < READ_LATENCY; i++) begin
                    inflight = inflight + CNT_W'(vld_q[i]);
                end
            end
            assign cap_vld  = vld_q[READ_LATENCY-1];
            assign cap_last = last_q[READ_LATENCY-1];
        end
    endgenerate

    mem_stream_buf_m #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (flush),
        .push_i     (cap_vld),
        .push_dat_i ({cap_last, rdata}),
        .pop_i      (pop),
        .pop_vld_o  (buf_vld),
        .pop_dat_o  (buf_dat),
        .count_o    (buf_cnt)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign raddr   = addr_q;
    assign m_valid = buf_vld;
    assign m_data  = buf_vld ? buf_dat[WORD_WIDTH-1:0] : '0;
    assign m_last  = buf_vld && buf_dat[WORD_WIDTH];

endmodule

// File: tb/tb_mem_stream_reader_m.sv
// Drives three readers (READ_LATENCY 0, 1, 2) with shared commands; each has its own RAM model.
module tb_mem_stream_reader_m;

    localparam int AW  = 8;
    localparam int WW  = 16;
    localparam int BIG = 1 << 30;

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  len;
        int          pct;
        logic [15:0] first_w;
        logic [15:0] last_w;
        bit          inject;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, start, m_ready;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
`ifdef MEM_STREAM_READER_ABORT_EN
    logic abort;
`endif

    logic          busy_w[3], done_w[3], m_valid_w[3], m_last_w[3];
    logic [AW-1:0] raddr_w[3];
    logic [WW-1:0] rdata_w[3], m_data_w[3];
    logic [3:0]    buf_cnt_w[3];
    logic [WW-1:0] mem [256];

    int n_cmp = 0, n_fail = 0, cyc = 0;
    bit mon_en = 1'b0, cmd_nz = 1'b0, full_rate = 1'b0, has_exp = 1'b0;
    int start_cyc = -10, cmd_len = 0, ready_pct = 100;
    logic [7:0]  cmd_base = '0;
    logic [15:0] tbl_first = '0, tbl_last = '0;
    int          rcv[3], done_exp[3], first_cyc[3];
    bit          seen_first[3], prev_stall[3];
    logic [WW-1:0] prev_dat[3];
    logic          prev_last[3];
    vec_t          vecs[7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        if (g == 0) begin : g_l0
            assign rdata_w[g] = mem[raddr_w[g]];
        end else if (g == 1) begin : g_l1
            logic [WW-1:0] p0;
            always @(posedge clk) p0 <= mem[raddr_w[g]];
            assign rdata_w[g] = p0;
        end else begin : g_l2
            logic [WW-1:0] p0, p1;
            always @(posedge clk) begin
                p0 <= mem[raddr_w[g]];
                p1 <= p0;
            end
            assign rdata_w[g] = p1;
        end

        mem_stream_reader_m #(
            .ADDR_WIDTH   (AW),
            .WORD_WIDTH   (WW),
            .READ_LATENCY (g)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .base_addr (base_addr),
            .len       (len),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .raddr     (raddr_w[g]),
            .rdata     (rdata_w[g]),
            .m_valid   (m_valid_w[g]),
            .m_data    (m_data_w[g]),
            .m_last    (m_last_w[g]),
            .m_ready   (m_ready)
`ifdef MEM_STREAM_READER_ABORT_EN
            ,
            .abort     (abort)
`endif
        );

        assign buf_cnt_w[g] = 4'(u_dut.u_buf.count_o);
    end

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, g, cyc, act, exp);
        end
    endtask

    function automatic logic pick_ready();
        return $urandom_range(99) < ready_pct;
    endfunction

    // Reference: word k of the command is mem[(base+k) mod 256]; last on k=len-1;
    // done/busy-low one cycle after the last handshake.
    task automatic monitor();
        if (!mon_en) return;
        for (int g = 0; g < 3; g++) begin
            check("done", g, done_w[g], cyc == done_exp[g]);
            check("busy", g, busy_w[g], cmd_nz && cyc > start_cyc && cyc < done_exp[g]);
            if (cmd_nz && cyc == start_cyc + 1) check("raddr_first", g, raddr_w[g], cmd_base);
            check("buf_within_depth", g, buf_cnt_w[g] <= 4'(g + 2), 1);
            if (prev_stall[g]) begin
                check("stall_valid", g, m_valid_w[g], 1);
                check("stall_data", g, m_data_w[g], prev_dat[g]);
                check("stall_last", g, m_last_w[g], prev_last[g]);
            end
            if (m_valid_w[g] && !seen_first[g]) begin
                seen_first[g] = 1'b1;
                first_cyc[g]  = cyc;
                check("first_latency", g, cyc - start_cyc, g + 2);
            end
            if (m_valid_w[g] && m_ready) begin
                if (rcv[g] < cmd_len) begin
                    check("data", g, m_data_w[g], mem[8'(cmd_base + rcv[g])]);
                    check("last", g, m_last_w[g], rcv[g] == cmd_len - 1);
                    if (has_exp && rcv[g] == 0) check("first_word", g, m_data_w[g], tbl_first);
                    if (rcv[g] == cmd_len - 1) begin
                        done_exp[g] = cyc + 1;
                        if (has_exp)   check("last_word", g, m_data_w[g], tbl_last);
                        if (full_rate) check("throughput", g, cyc - first_cyc[g], cmd_len - 1);
                    end
                end else begin
                    check("extra_word", g, m_valid_w[g], 0);
                end
                rcv[g]++;
            end
            prev_stall[g] = m_valid_w[g] && !m_ready;
            prev_dat[g]   = m_data_w[g];
            prev_last[g]  = m_last_w[g];
        end
    endtask

    task automatic tick();
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_cmd(input vec_t v, input bit exp_en);
        cmd_base  = v.base;
        cmd_len   = int'(v.len);
        ready_pct = v.pct;
        full_rate = (v.pct >= 100);
        has_exp   = exp_en;
        tbl_first = v.first_w;
        tbl_last  = v.last_w;
        cmd_nz    = (v.len != 0);
        start_cyc = cyc;
        for (int g = 0; g < 3; g++) begin
            rcv[g]        = 0;
            seen_first[g] = 1'b0;
            prev_stall[g] = 1'b0;
            done_exp[g]   = (v.len == 0) ? cyc + 1 : BIG;
        end
        base_addr = v.base;
        len       = v.len;
        start     = 1'b1;
        m_ready   = pick_ready();
        tick();
        start = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input bit exp_en);
        bit all_done;
        begin_cmd(v, exp_en);
        all_done = 1'b0;
        for (int t = 0; t < 3000 && !all_done; t++) begin
            all_done = 1'b1;
            for (int g = 0; g < 3; g++) if (cyc <= done_exp[g]) all_done = 1'b0;
            if (!all_done) begin
                // A second start while busy must be ignored.
                if (v.inject && cyc == start_cyc + 5) begin
                    start = 1'b1; base_addr = 8'h77; len = 9'd3;
                end else begin
                    start = 1'b0;
                end
                m_ready = pick_ready();
                tick();
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!all_done) begin
            n_fail++;
            $display("FAIL cmd_timeout base=%0h len=%0d got=not_done want=done", v.base, v.len);
        end
        for (int g = 0; g < 3; g++) check("word_count", g, rcv[g], cmd_len);
        m_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = '0; len = '0;
`ifdef MEM_STREAM_READER_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 16'(16'h100 + i);
        for (int g = 0; g < 3; g++) begin
            rcv[g] = 0; done_exp[g] = BIG; first_cyc[g] = 0;
            seen_first[g] = 1'b0; prev_stall[g] = 1'b0;
        end
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            check("rst_busy", g, busy_w[g], 0);
            check("rst_done", g, done_w[g], 0);
            check("rst_raddr", g, raddr_w[g], 0);
            check("rst_valid", g, m_valid_w[g], 0);
            check("rst_data", g, m_data_w[g], 0);
            check("rst_last", g, m_last_w[g], 0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        vecs[0] = '{8'd5,   9'd4,   100, 16'h105, 16'h108, 1'b0};
        vecs[1] = '{8'd254, 9'd4,   100, 16'h1FE, 16'h101, 1'b0};
        vecs[2] = '{8'h30,  9'd16,  50,  16'h130, 16'h13F, 1'b1};
        vecs[3] = '{8'd0,   9'd256, 100, 16'h100, 16'h1FF, 1'b0};
        vecs[4] = '{8'h80,  9'd1,   100, 16'h180, 16'h180, 1'b0};
        vecs[5] = '{8'h10,  9'd0,   100, 16'h000, 16'h000, 1'b0};
        vecs[6] = '{8'hFF,  9'd2,   30,  16'h1FF, 16'h100, 1'b0};
        for (int i = 0; i < 7; i++) run_cmd(vecs[i], 1'b1);

        // Reset in the middle of an 8-word command.
        v = '{8'h00, 9'd8, 100, 16'h0, 16'h0, 1'b0};
        begin_cmd(v, 1'b0);
        for (int t = 0; t < 40 && rcv[1] < 3; t++) tick();
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("midrst_busy", g, busy_w[g], 0);
            check("midrst_done", g, done_w[g], 0);
            check("midrst_raddr", g, raddr_w[g], 0);
            check("midrst_valid", g, m_valid_w[g], 0);
            check("midrst_data", g, m_data_w[g], 0);
            check("midrst_last", g, m_last_w[g], 0);
        end
        tick();
        tick();
        rst_n  = 1'b1;
        cmd_nz = 1'b0;
        for (int g = 0; g < 3; g++) done_exp[g] = BIG;
        mon_en = 1'b1;
        tick();
        v = '{8'h20, 9'd8, 100, 16'h120, 16'h127, 1'b0};
        run_cmd(v, 1'b1);

`ifdef MEM_STREAM_READER_ABORT_EN
        v = '{8'h40, 9'd16, 100, 16'h0, 16'h0, 1'b0};
        begin_cmd(v, 1'b0);
        for (int t = 0; t < 40 && rcv[0] < 3; t++) tick();
        abort = 1'b1;
        for (int g = 0; g < 3; g++) done_exp[g] = cyc + 1;
        tick();
        abort = 1'b0;
        for (int g = 0; g < 3; g++) check("abort_valid", g, m_valid_w[g], 0);
        tick();
        tick();
        for (int g = 0; g < 3; g++) check("abort_short", g, rcv[g] < 16, 1);
`endif

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            v.base    = 8'($urandom);
            v.len     = 9'($urandom_range(40, 1));
            v.pct     = int'($urandom_range(100, 20));
            v.first_w = '0;
            v.last_w  = '0;
            v.inject  = 1'b0;
            run_cmd(v, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
